// File: rtl/data_mem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the byte-lane mask helper used to form store byte-enables.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WAIT   = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << off;
      SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Word-addressed storage with per-byte write enables and a read register
// that loads on every enabled access. Contents are intentionally not reset.
module dmem_byte_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];
  logic [31:0] rdata_r;

  // Read-before-write access: the read register captures the old word
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_r <= mem_r[addr];
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with programmable wait states,
// alignment/range checking and right-aligned zero-extended load data.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

  state_t      state_r;
  state_t      next_s;
  logic [3:0]  cnt_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [1:0]  size_r;
  logic [31:0] wdata_r;
  logic        fill_r;
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic        rsp_err_r;
  logic [31:0] rsp_rdata_r;

  logic        accept_s;
  logic        align_err_s;
  logic        range_err_s;
  logic        err_s;
  logic        mem_en_s;
  logic [3:0]  mem_be_s;
  logic [31:0] mem_wdata_s;
  logic [31:0] mem_rdata_s;
  logic [31:0] shifted_s;
  logic [31:0] load_s;

  assign accept_s    = (state_r == ST_IDLE) && req_valid && req_ready_r;
  assign range_err_s = ({2'b00, addr_r[31:2]} >= DEPTH_L);
  assign err_s       = align_err_s || range_err_s;

  // Alignment rules per access size; the illegal encoding always errors
  always_comb begin
    case (size_r)
      SZ_BYTE: align_err_s = 1'b0;
      SZ_HALF: align_err_s = addr_r[0];
      SZ_WORD: align_err_s = (addr_r[1:0] != 2'b00);
      default: align_err_s = 1'b1;
    endcase
  end

  // Replicate store data so every candidate lane sees the right bytes
  always_comb begin
    case (size_r)
      SZ_BYTE: mem_wdata_s = {4{wdata_r[7:0]}};
      SZ_HALF: mem_wdata_s = {2{wdata_r[15:0]}};
      default: mem_wdata_s = wdata_r;
    endcase
  end

  assign mem_be_s  = lane_mask(size_r, addr_r[1:0]) & {4{we_r}};
  assign mem_en_s  = (state_r == ST_ACCESS) && !err_s;
  assign shifted_s = mem_rdata_s >> {addr_r[1:0], 3'b000};

  // Load data right-aligned and zero-extended to the access size
  always_comb begin
    case (size_r)
      SZ_BYTE: load_s = {24'h000000, shifted_s[7:0]};
      SZ_HALF: load_s = {16'h0000, shifted_s[15:0]};
      SZ_WORD: load_s = shifted_s;
      default: load_s = 32'h0000_0000;
    endcase
  end

  // Next-state logic of the request FSM
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_s = (WAIT_L == 4'd0) ? ST_ACCESS : ST_WAIT;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= 4'd1) begin
          next_s = ST_ACCESS;
        end else begin
          next_s = ST_WAIT;
        end
      end
      ST_ACCESS: next_s = ST_RESP;
      ST_RESP: begin
        if (rsp_valid_r && rsp_ready) begin
          next_s = ST_IDLE;
        end else begin
          next_s = ST_RESP;
        end
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // FSM, wait counter and response registers; fill_r marks the cycle in
  // which the array read register is aligned into the response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      req_ready_r <= 1'b0;
      fill_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
    end else begin
      state_r     <= next_s;
      req_ready_r <= (next_s == ST_IDLE);
      fill_r      <= (state_r == ST_ACCESS);
      if (accept_s) begin
        cnt_r <= WAIT_L;
      end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (fill_r) begin
        rsp_valid_r <= 1'b1;
        rsp_err_r   <= err_s;
        rsp_rdata_r <= (err_s || we_r) ? 32'h0000_0000 : load_s;
      end else if (rsp_valid_r && rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  // Request capture on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_r    <= 1'b0;
      addr_r  <= 32'h0000_0000;
      size_r  <= SZ_BYTE;
      wdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      we_r    <= req_we;
      addr_r  <= req_addr;
      size_r  <= req_size;
      wdata_r <= req_wdata;
    end
  end

  dmem_byte_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .en   (mem_en_s),
    .addr (addr_r[AW+1:2]),
    .be   (mem_be_s),
    .wdata(mem_wdata_s),
    .rdata(mem_rdata_s)
  );

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance a uses WAIT_CYCLES=2, instance b WAIT_CYCLES=0.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;

  logic        vld_a, rdy_a, rsp_valid_a, rready_a, err_a;
  logic [31:0] rdata_a;
  logic        vld_b, rdy_b, rsp_valid_b, rready_b, err_b;
  logic [31:0] rdata_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .req_valid(vld_a), .req_ready(rdy_a), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_ready(rready_a), .rsp_rdata(rdata_a), .rsp_err(err_a)
  );

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(vld_b), .req_ready(rdy_b), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_ready(rready_b), .rsp_rdata(rdata_b), .rsp_err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance s with latency, ready-wait and result checks
  task automatic op(input int s, input string tag, input logic we, input logic [31:0] addr,
                    input logic [1:0] size, input logic [31:0] wd,
                    input logic [31:0] exp_rd, input logic exp_err);
    int wt;
    int lat;
    logic [31:0] rd;
    logic er;
    wt = 0;
    while ((((s == 0) ? rdy_a : rdy_b) !== 1'b1) && (wt < 50)) begin
      @(posedge clk); #1; wt++;
    end
    req_we = we; req_addr = addr; req_size = size; req_wdata = wd;
    if (s == 0) vld_a = 1'b1; else vld_b = 1'b1;
    @(posedge clk); #1;
    vld_a = 1'b0; vld_b = 1'b0;
    lat = 0;
    while ((((s == 0) ? rsp_valid_a : rsp_valid_b) !== 1'b1) && (lat < 50)) begin
      @(posedge clk); #1; lat++;
    end
    rd = (s == 0) ? rdata_a : rdata_b;
    er = (s == 0) ? err_a : err_b;
    if (s == 0) rready_a = 1'b1; else rready_b = 1'b1;
    @(posedge clk); #1;
    rready_a = 1'b0; rready_b = 1'b0;
    chk({tag, "/ready_wait"}, 32'(wt), 32'd0);
    chk({tag, "/latency"}, 32'(lat), (s == 0) ? 32'd4 : 32'd2);
    chk({tag, "/rdata"}, rd, exp_rd);
    chk({tag, "/err"}, {31'd0, er}, {31'd0, exp_err});
  endtask

  initial begin
    int lat;
    rst = 1'b0;
    vld_a = 1'b0; vld_b = 1'b0; rready_a = 1'b0; rready_b = 1'b0;
    req_we = 1'b0; req_addr = 32'h0; req_size = 2'd0; req_wdata = 32'h0;

    // Reset values, then ready one edge after release
    repeat (3) @(posedge clk);
    #1;
    chk("rst/req_ready", {31'd0, rdy_a}, 32'd0);
    chk("rst/rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
    chk("rst/rsp_err", {31'd0, err_a}, 32'd0);
    chk("rst/rsp_rdata", rdata_a, 32'h0);
    chk("rst/req_ready_b", {31'd0, rdy_b}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst/ready_rise", {31'd0, rdy_a}, 32'd1);
    chk("rst/ready_rise_b", {31'd0, rdy_b}, 32'd1);

    // Word store then load
    op(0, "st40", 1'b1, 32'h40, 2'd2, 32'hDEADBEEF, 32'h0, 1'b0);
    op(0, "ld40", 1'b0, 32'h40, 2'd2, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte and half lanes
    op(0, "st80", 1'b1, 32'h80, 2'd2, 32'h11223344, 32'h0, 1'b0);
    op(0, "sb81", 1'b1, 32'h81, 2'd0, 32'hFFFFFFAA, 32'h0, 1'b0);
    op(0, "sh82", 1'b1, 32'h82, 2'd1, 32'hFFFF5566, 32'h0, 1'b0);
    op(0, "ld80", 1'b0, 32'h80, 2'd2, 32'h0, 32'h5566AA44, 1'b0);
    op(0, "lb83", 1'b0, 32'h83, 2'd0, 32'h0, 32'h00000055, 1'b0);
    op(0, "lb81", 1'b0, 32'h81, 2'd0, 32'h0, 32'h000000AA, 1'b0);
    op(0, "lh82", 1'b0, 32'h82, 2'd1, 32'h0, 32'h00005566, 1'b0);

    // Error cases leave memory untouched
    op(0, "pre100", 1'b1, 32'h100, 2'd2, 32'hCAFEF00D, 32'h0, 1'b0);
    op(0, "pre200", 1'b1, 32'h200, 2'd2, 32'h0BADC0DE, 32'h0, 1'b0);
    op(0, "pre0", 1'b1, 32'h0, 2'd2, 32'h13579BDF, 32'h0, 1'b0);
    op(0, "lh101", 1'b0, 32'h101, 2'd1, 32'h0, 32'h0, 1'b1);
    op(0, "sw202", 1'b1, 32'h202, 2'd2, 32'hFFFFFFFF, 32'h0, 1'b1);
    op(0, "re200", 1'b0, 32'h200, 2'd2, 32'h0, 32'h0BADC0DE, 1'b0);
    op(0, "sz3", 1'b1, 32'h100, 2'd3, 32'hFFFFFFFF, 32'h0, 1'b1);
    op(0, "re100", 1'b0, 32'h100, 2'd2, 32'h0, 32'hCAFEF00D, 1'b0);
    op(0, "sw1000", 1'b1, 32'h1000, 2'd2, 32'hFFFFFFFF, 32'h0, 1'b1);
    op(0, "lw1000", 1'b0, 32'h1000, 2'd2, 32'h0, 32'h0, 1'b1);
    op(0, "re0", 1'b0, 32'h0, 2'd2, 32'h0, 32'h13579BDF, 1'b0);

    // Back-pressure with a stray request held during RESP
    req_we = 1'b0; req_addr = 32'h40; req_size = 2'd2;
    vld_a = 1'b1;
    @(posedge clk); #1;
    vld_a = 1'b1; req_addr = 32'h80;
    lat = 0;
    while ((rsp_valid_a !== 1'b1) && (lat < 50)) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp/latency", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      chk("bp/rsp_valid", {31'd0, rsp_valid_a}, 32'd1);
      chk("bp/rsp_rdata", rdata_a, 32'hDEADBEEF);
      chk("bp/rsp_err", {31'd0, err_a}, 32'd0);
      chk("bp/req_ready", {31'd0, rdy_a}, 32'd0);
      @(posedge clk); #1;
    end
    vld_a = 1'b0;
    rready_a = 1'b1;
    @(posedge clk); #1;
    rready_a = 1'b0;
    chk("bp/valid_drop", {31'd0, rsp_valid_a}, 32'd0);
    chk("bp/idle_ready", {31'd0, rdy_a}, 32'd1);

    // Reset during WAIT discards the store
    op(0, "pre10", 1'b1, 32'h10, 2'd2, 32'hA5A5A5A5, 32'h0, 1'b0);
    req_we = 1'b1; req_addr = 32'h10; req_size = 2'd2; req_wdata = 32'h12345678;
    vld_a = 1'b1;
    @(posedge clk); #1;
    vld_a = 1'b0;
    chk("mid/accepted", {31'd0, rdy_a}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid/req_ready", {31'd0, rdy_a}, 32'd0);
    chk("mid/rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
    chk("mid/rsp_err", {31'd0, err_a}, 32'd0);
    chk("mid/rsp_rdata", rdata_a, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid/ready_rise", {31'd0, rdy_a}, 32'd1);
    op(0, "mid/re10", 1'b0, 32'h10, 2'd2, 32'h0, 32'hA5A5A5A5, 1'b0);

    // Zero wait states: back-to-back accesses
    op(1, "b_st4", 1'b1, 32'h4, 2'd2, 32'h0F0F80F0, 32'h0, 1'b0);
    op(1, "b_ld4", 1'b0, 32'h4, 2'd2, 32'h0, 32'h0F0F80F0, 1'b0);
    op(1, "b_lh6", 1'b0, 32'h6, 2'd1, 32'h0, 32'h00000F0F, 1'b0);
    op(1, "b_lb5", 1'b0, 32'h5, 2'd0, 32'h0, 32'h00000080, 1'b0);
    op(1, "b_oor", 1'b0, 32'h100, 2'd2, 32'h0, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
